// File: rtl/decode_stage_hs.sv
// decode_stage_hs: pipelined-core ID stage with IF/EX valid-ready handshakes.
// Decodes the IF instruction, reads the register file (with a write-back bypass),
// computes the branch target and registers the result into the ID/EX register.
// A load-use interlock inserts bubbles and counts them; flush_ex kills both the
// ID/EX contents and the instruction being offered.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid_if / in_ready_id       IF -> ID handshake (in_ready_id combinational)
//   instruction_if, next_program_counter_if, branch_prediction_bp   IF payload
//   reg1_index_rf / reg2_index_rf   RF read indices (combinational)
//   reg1_data_rf / reg2_data_rf     same-cycle RF read data
//   wb_en_wb, wb_idx_wb, wb_data_wb write-back port for bypass
//   flush_ex                        mispredict kill from EX
//   out_valid_id / out_ready_ex     ID -> EX handshake
//   opcode_id .. illegal_id         registered ID/EX payload
//   bubble_count_id                 saturating load-use bubble count
module decode_stage_hs #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned REG_IDX_W = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_if,
  output logic                 in_ready_id,
  input  logic [INSTR_W-1:0]   instruction_if,
  input  logic [DATA_W-1:0]    next_program_counter_if,
  input  logic                 branch_prediction_bp,
  output logic [REG_IDX_W-1:0] reg1_index_rf,
  output logic [REG_IDX_W-1:0] reg2_index_rf,
  input  logic [DATA_W-1:0]    reg1_data_rf,
  input  logic [DATA_W-1:0]    reg2_data_rf,
  input  logic                 wb_en_wb,
  input  logic [REG_IDX_W-1:0] wb_idx_wb,
  input  logic [DATA_W-1:0]    wb_data_wb,
  input  logic                 flush_ex,
  output logic                 out_valid_id,
  input  logic                 out_ready_ex,
  output logic [3:0]           opcode_id,
  output logic [REG_IDX_W-1:0] dest_reg_index_id,
  output logic [DATA_W-1:0]    reg1_data_id,
  output logic [DATA_W-1:0]    reg2_data_id,
  output logic [DATA_W-1:0]    immediate_id,
  output logic [DATA_W-1:0]    target_address_id,
  output logic [DATA_W-1:0]    next_program_counter_id,
  output logic                 prediction_id,
  output logic [5:0]           control_id,
  output logic                 illegal_id,
  output logic [CNT_W-1:0]     bubble_count_id
);

  localparam int unsigned IMM_W   = INSTR_W - 4 - 2*REG_IDX_W;
  localparam int unsigned RD_MSB  = INSTR_W - 5;
  localparam int unsigned RS1_MSB = RD_MSB - REG_IDX_W;
  localparam int unsigned RS2_MSB = RS1_MSB - REG_IDX_W;

  localparam logic [3:0] OP_LOAD  = 4'd9;

  // control bit order: {jump, branch, mem_wr, mem_rd, alu_imm, reg_wr}
  localparam logic [5:0] CTL_RTYPE = 6'b000001;
  localparam logic [5:0] CTL_ADDI  = 6'b000011;
  localparam logic [5:0] CTL_LOAD  = 6'b000111;
  localparam logic [5:0] CTL_STORE = 6'b001010;
  localparam logic [5:0] CTL_BEQ   = 6'b010000;
  localparam logic [5:0] CTL_JMP   = 6'b100000;

  // Instruction fields
  logic [3:0]           w_opcode;
  logic [REG_IDX_W-1:0] w_rd;
  logic [REG_IDX_W-1:0] w_rs1;
  logic [REG_IDX_W-1:0] w_rs2;
  logic [IMM_W-1:0]     w_imm;
  logic [DATA_W-1:0]    w_imm_sext;
  logic [DATA_W-1:0]    w_target;

  assign w_opcode   = instruction_if[INSTR_W-1 -: 4];
  assign w_rd       = instruction_if[RD_MSB  -: REG_IDX_W];
  assign w_rs1      = instruction_if[RS1_MSB -: REG_IDX_W];
  assign w_rs2      = instruction_if[RS2_MSB -: REG_IDX_W];
  assign w_imm      = instruction_if[IMM_W-1:0];
  assign w_imm_sext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_target   = next_program_counter_if + w_imm_sext;

  // Decode: control word, legality and which sources the instruction reads
  logic [5:0] w_ctrl;
  logic       w_illegal;
  logic       w_use_rs1;
  logic       w_use_src2;
  logic       w_src2_is_rd;

  always_comb begin
    w_ctrl       = '0;
    w_illegal    = 1'b0;
    w_use_rs1    = 1'b0;
    w_use_src2   = 1'b0;
    w_src2_is_rd = 1'b0;
    case (w_opcode)
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        w_ctrl     = CTL_RTYPE;
        w_use_rs1  = 1'b1;
        w_use_src2 = 1'b1;
      end
      4'd8: begin
        w_ctrl    = CTL_ADDI;
        w_use_rs1 = 1'b1;
      end
      4'd9: begin
        w_ctrl    = CTL_LOAD;
        w_use_rs1 = 1'b1;
      end
      4'd10: begin
        w_ctrl       = CTL_STORE;
        w_use_rs1    = 1'b1;
        w_use_src2   = 1'b1;
        w_src2_is_rd = 1'b1;
      end
      4'd11: begin
        w_ctrl       = CTL_BEQ;
        w_use_rs1    = 1'b1;
        w_use_src2   = 1'b1;
        w_src2_is_rd = 1'b1;
      end
      4'd12: w_ctrl = CTL_JMP;
      default: w_illegal = 1'b1;
    endcase
  end

  // STORE/BEQ read rd through port 2 (store data / compare operand)
  logic [REG_IDX_W-1:0] w_src2;
  assign w_src2        = w_src2_is_rd ? w_rd : w_rs2;
  assign reg1_index_rf = w_rs1;
  assign reg2_index_rf = w_src2;

  // Operand select: r0 hardwired to zero, then write-back bypass, then RF
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  assign w_op1 = (w_rs1 == '0) ? '0 :
                 (wb_en_wb && (wb_idx_wb == w_rs1)) ? wb_data_wb : reg1_data_rf;
  assign w_op2 = (w_src2 == '0) ? '0 :
                 (wb_en_wb && (wb_idx_wb == w_src2)) ? wb_data_wb : reg2_data_rf;

  // ID/EX pipeline registers
  logic                 r_valid;
  logic [3:0]           r_opcode;
  logic [REG_IDX_W-1:0] r_dest;
  logic [DATA_W-1:0]    r_data1;
  logic [DATA_W-1:0]    r_data2;
  logic [DATA_W-1:0]    r_imm;
  logic [DATA_W-1:0]    r_target;
  logic [DATA_W-1:0]    r_next_pc;
  logic                 r_pred;
  logic [5:0]           r_ctrl;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_bubble_cnt;

  // Load-use: the load in ID/EX has no result yet for a dependent instruction
  logic w_load_use;
  logic w_advance;
  assign w_load_use = r_valid && (r_opcode == OP_LOAD) && (r_dest != '0) && in_valid_if &&
                      ((w_use_rs1 && (w_rs1 == r_dest)) || (w_use_src2 && (w_src2 == r_dest)));
  assign w_advance  = !r_valid || out_ready_ex;
  assign in_ready_id = flush_ex || (w_advance && !w_load_use);

  // ID/EX update: flush > bubble > advance > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_dest       <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_imm        <= '0;
      r_target     <= '0;
      r_next_pc    <= '0;
      r_pred       <= 1'b0;
      r_ctrl       <= '0;
      r_illegal    <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush_ex) begin
      r_valid <= 1'b0;
    end else if (w_advance && w_load_use) begin
      r_valid <= 1'b0;
      if (r_bubble_cnt != {CNT_W{1'b1}}) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else if (w_advance) begin
      r_valid <= in_valid_if;
      if (in_valid_if) begin
        r_opcode  <= w_opcode;
        r_dest    <= w_rd;
        r_data1   <= w_op1;
        r_data2   <= w_op2;
        r_imm     <= w_imm_sext;
        r_target  <= w_target;
        r_next_pc <= next_program_counter_if;
        r_pred    <= branch_prediction_bp;
        r_ctrl    <= w_ctrl;
        r_illegal <= w_illegal;
      end
    end
  end

  assign out_valid_id            = r_valid;
  assign opcode_id               = r_opcode;
  assign dest_reg_index_id       = r_dest;
  assign reg1_data_id            = r_data1;
  assign reg2_data_id            = r_data2;
  assign immediate_id            = r_imm;
  assign target_address_id       = r_target;
  assign next_program_counter_id = r_next_pc;
  assign prediction_id           = r_pred;
  assign control_id              = r_ctrl;
  assign illegal_id              = r_illegal;
  assign bubble_count_id         = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Testbench for decode_stage_hs: directed instruction stream against a
// behavioural reference of the ID stage, plus hand-computed literal checks.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid_if;
  logic        in_ready_id;
  logic [15:0] instruction_if;
  logic [15:0] next_program_counter_if;
  logic        branch_prediction_bp;
  logic [2:0]  reg1_index_rf;
  logic [2:0]  reg2_index_rf;
  logic [15:0] reg1_data_rf;
  logic [15:0] reg2_data_rf;
  logic        wb_en_wb;
  logic [2:0]  wb_idx_wb;
  logic [15:0] wb_data_wb;
  logic        flush_ex;
  logic        out_valid_id;
  logic        out_ready_ex;
  logic [3:0]  opcode_id;
  logic [2:0]  dest_reg_index_id;
  logic [15:0] reg1_data_id;
  logic [15:0] reg2_data_id;
  logic [15:0] immediate_id;
  logic [15:0] target_address_id;
  logic [15:0] next_program_counter_id;
  logic        prediction_id;
  logic [5:0]  control_id;
  logic        illegal_id;
  logic [15:0] bubble_count_id;

  decode_stage_hs #(
    .DATA_W(16), .INSTR_W(16), .REG_IDX_W(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_if(in_valid_if), .in_ready_id(in_ready_id),
    .instruction_if(instruction_if),
    .next_program_counter_if(next_program_counter_if),
    .branch_prediction_bp(branch_prediction_bp),
    .reg1_index_rf(reg1_index_rf), .reg2_index_rf(reg2_index_rf),
    .reg1_data_rf(reg1_data_rf), .reg2_data_rf(reg2_data_rf),
    .wb_en_wb(wb_en_wb), .wb_idx_wb(wb_idx_wb), .wb_data_wb(wb_data_wb),
    .flush_ex(flush_ex),
    .out_valid_id(out_valid_id), .out_ready_ex(out_ready_ex),
    .opcode_id(opcode_id), .dest_reg_index_id(dest_reg_index_id),
    .reg1_data_id(reg1_data_id), .reg2_data_id(reg2_data_id),
    .immediate_id(immediate_id), .target_address_id(target_address_id),
    .next_program_counter_id(next_program_counter_id),
    .prediction_id(prediction_id), .control_id(control_id),
    .illegal_id(illegal_id), .bubble_count_id(bubble_count_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file contents seen on the RF read ports (r0 deliberately non-zero)
  logic [15:0] rf [8];
  // Control word per opcode: {jump,branch,mem_wr,mem_rd,alu_imm,reg_wr}
  logic [5:0]  ctrl_tab [16];

  // Reference ID/EX state
  logic        m_valid;
  logic [3:0]  m_op;
  logic [2:0]  m_rd;
  logic [15:0] m_d1, m_d2, m_imm, m_tgt, m_npc;
  logic        m_pred;
  logic [5:0]  m_ctrl;
  logic        m_ill;
  logic [15:0] m_cnt;
  logic        s_in_ready;

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    m_tgt = 0; m_npc = 0; m_pred = 0; m_ctrl = 0; m_ill = 0; m_cnt = 0;
  endtask

  function automatic logic [15:0] operand(input logic [2:0] idx, input logic we,
                                          input logic [2:0] wi, input logic [15:0] wd);
    if (idx == 3'd0) return 16'h0;
    if (we && wi == idx) return wd;
    return rf[idx];
  endfunction

  task automatic check_regs();
    chk("out_valid_id", 32'(out_valid_id), 32'(m_valid));
    chk("bubble_count_id", 32'(bubble_count_id), 32'(m_cnt));
    if (m_valid) begin
      chk("opcode_id", 32'(opcode_id), 32'(m_op));
      chk("dest_reg_index_id", 32'(dest_reg_index_id), 32'(m_rd));
      chk("reg1_data_id", 32'(reg1_data_id), 32'(m_d1));
      chk("reg2_data_id", 32'(reg2_data_id), 32'(m_d2));
      chk("immediate_id", 32'(immediate_id), 32'(m_imm));
      chk("target_address_id", 32'(target_address_id), 32'(m_tgt));
      chk("next_program_counter_id", 32'(next_program_counter_id), 32'(m_npc));
      chk("prediction_id", 32'(prediction_id), 32'(m_pred));
      chk("control_id", 32'(control_id), 32'(m_ctrl));
      chk("illegal_id", 32'(illegal_id), 32'(m_ill));
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the
  // reference at the edge, check registered outputs just after it.
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] npc,
                      input logic bp, input logic rdy, input logic fl,
                      input logic we, input logic [2:0] wi, input logic [15:0] wd);
    logic [3:0]  op;
    logic [2:0]  rd, rs1, src2;
    logic        u1, u2, lu, adv;
    op   = ins[15:12];
    rd   = ins[11:9];
    rs1  = ins[8:6];
    src2 = (op == 4'd10 || op == 4'd11) ? rd : ins[5:3];
    u1   = (op >= 4'd1 && op <= 4'd11);
    u2   = (op >= 4'd1 && op <= 4'd7) || op == 4'd10 || op == 4'd11;
    in_valid_if = v; instruction_if = ins; next_program_counter_if = npc;
    branch_prediction_bp = bp; out_ready_ex = rdy; flush_ex = fl;
    wb_en_wb = we; wb_idx_wb = wi; wb_data_wb = wd;
    reg1_data_rf = rf[rs1];
    reg2_data_rf = rf[src2];
    #1;
    lu  = m_valid && m_op == 4'd9 && m_rd != 3'd0 && v &&
          ((u1 && rs1 == m_rd) || (u2 && src2 == m_rd));
    adv = !m_valid || rdy;
    chk("in_ready_id", 32'(in_ready_id), 32'(fl || (adv && !lu)));
    chk("reg1_index_rf", 32'(reg1_index_rf), 32'(rs1));
    chk("reg2_index_rf", 32'(reg2_index_rf), 32'(src2));
    s_in_ready = in_ready_id;
    @(posedge clk);
    if (fl) begin
      m_valid = 0;
    end else if (adv && lu) begin
      m_valid = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (adv) begin
      m_valid = v;
      if (v) begin
        m_op   = op;
        m_rd   = rd;
        m_d1   = operand(rs1, we, wi, wd);
        m_d2   = operand(src2, we, wi, wd);
        m_imm  = {{10{ins[5]}}, ins[5:0]};
        m_tgt  = npc + m_imm;
        m_npc  = npc;
        m_pred = bp;
        m_ctrl = ctrl_tab[op];
        m_ill  = (op >= 4'd13);
      end
    end
    #2;
    check_regs();
    @(negedge clk);
  endtask

  task automatic go(input logic [15:0] ins, input logic [15:0] npc, input logic rdy);
    step(1'b1, ins, npc, 1'b0, rdy, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  // Async reset: outputs must clear without a clock edge
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst out_valid_id", 32'(out_valid_id), 32'h0);
    chk("rst bubble_count_id", 32'(bubble_count_id), 32'h0);
    chk("rst opcode_id", 32'(opcode_id), 32'h0);
    chk("rst control_id", 32'(control_id), 32'h0);
    chk("rst target_address_id", 32'(target_address_id), 32'h0);
    chk("rst reg1_data_id", 32'(reg1_data_id), 32'h0);
    chk("rst prediction_id", 32'(prediction_id), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rf[0] = 16'hDEAD; rf[1] = 16'h0005; rf[2] = 16'h0007; rf[3] = 16'h1234;
    rf[4] = 16'h00FF; rf[5] = 16'hA5A5; rf[6] = 16'h8000; rf[7] = 16'hFFFF;
    ctrl_tab[0] = 6'b000000;
    for (int i = 1; i <= 7; i++) ctrl_tab[i] = 6'b000001;
    ctrl_tab[8]  = 6'b000011; ctrl_tab[9]  = 6'b000111; ctrl_tab[10] = 6'b001010;
    ctrl_tab[11] = 6'b010000; ctrl_tab[12] = 6'b100000;
    for (int i = 13; i <= 15; i++) ctrl_tab[i] = 6'b000000;

    in_valid_if = 0; instruction_if = 0; next_program_counter_if = 0;
    branch_prediction_bp = 0; reg1_data_rf = 0; reg2_data_rf = 0;
    wb_en_wb = 0; wb_idx_wb = 0; wb_data_wb = 0; flush_ex = 0; out_ready_ex = 1;
    model_reset();
    s_in_ready = 0;

    do_reset();
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

    // ADD r3 = r1 + r2
    go(16'h1650, 16'h0005, 1'b1);
    chk("add opcode", 32'(opcode_id), 32'h1);
    chk("add dest", 32'(dest_reg_index_id), 32'h3);
    chk("add data1", 32'(reg1_data_id), 32'h5);
    chk("add data2", 32'(reg2_data_id), 32'h7);
    chk("add control", 32'(control_id), 32'h01);

    // LOAD r2 then dependent ADD: one bubble
    go(16'h9444, 16'h0006, 1'b1);
    chk("load control", 32'(control_id), 32'h07);
    go(16'h1650, 16'h0007, 1'b1);
    chk("loaduse in_ready", 32'(s_in_ready), 32'h0);
    chk("loaduse bubble valid", 32'(out_valid_id), 32'h0);
    chk("loaduse count", 32'(bubble_count_id), 32'h1);
    go(16'h1650, 16'h0007, 1'b1);
    chk("loaduse issue valid", 32'(out_valid_id), 32'h1);
    chk("loaduse issue opcode", 32'(opcode_id), 32'h1);

    // BEQ with negative offset, predicted taken
    step(1'b1, 16'hB03E, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("beq target", 32'(target_address_id), 32'h000E);
    chk("beq prediction", 32'(prediction_id), 32'h1);
    chk("beq control", 32'(control_id), 32'h10);

    // EX stall for three cycles, then flush
    go(16'h8A47, 16'h0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      go(16'hA2C5, 16'h0012, 1'b0);
      chk("stall in_ready", 32'(s_in_ready), 32'h0);
      chk("stall held opcode", 32'(opcode_id), 32'h8);
      chk("stall held valid", 32'(out_valid_id), 32'h1);
    end
    step(1'b1, 16'hA2C5, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("flush in_ready", 32'(s_in_ready), 32'h1);
    chk("flush valid", 32'(out_valid_id), 32'h0);

    // Write-back bypass, and r0 ignoring a write-back to index 0
    step(1'b1, 16'h1650, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'hBEEF);
    chk("bypass data2", 32'(reg2_data_id), 32'hBEEF);
    chk("bypass data1", 32'(reg1_data_id), 32'h5);
    step(1'b1, 16'h1600, 16'h0021, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'hBEEF);
    chk("r0 data1", 32'(reg1_data_id), 32'h0);
    chk("r0 data2", 32'(reg2_data_id), 32'h0);

    // STORE, JMP, illegal, idle
    go(16'hA2C5, 16'h0022, 1'b1);
    chk("store data2 is rd", 32'(reg2_data_id), 32'h5);
    go(16'hC03F, 16'h0020, 1'b1);
    chk("jmp target", 32'(target_address_id), 32'h001F);
    go(16'hD123, 16'h0024, 1'b1);
    chk("illegal flag", 32'(illegal_id), 32'h1);
    chk("illegal control", 32'(control_id), 32'h0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

    // LOAD to r0 never interlocks; LOAD then STORE of loaded reg does
    go(16'h9044, 16'h0030, 1'b1);
    go(16'h1000, 16'h0031, 1'b1);
    chk("load r0 no stall", 32'(s_in_ready), 32'h1);
    go(16'h9444, 16'h0032, 1'b1);
    go(16'hA4C0, 16'h0033, 1'b1);
    chk("store loaduse in_ready", 32'(s_in_ready), 32'h0);
    go(16'hA4C0, 16'h0033, 1'b1);
    go(16'h9444, 16'h0034, 1'b1);
    go(16'hC000, 16'h0035, 1'b1);
    chk("jmp after load no stall", 32'(s_in_ready), 32'h1);

    // Load-use while EX stalls: hold first, bubble once EX frees up
    go(16'h9444, 16'h0036, 1'b1);
    go(16'h1650, 16'h0037, 1'b0);
    go(16'h1650, 16'h0037, 1'b0);
    go(16'h1650, 16'h0037, 1'b1);
    chk("stalled loaduse count", 32'(bubble_count_id), 32'h3);
    go(16'h1650, 16'h0037, 1'b1);

    // Reset in the middle of an EX stall
    go(16'h1650, 16'h0040, 1'b0);
    go(16'h8A47, 16'h0041, 1'b0);
    do_reset();
    go(16'h8A47, 16'h0042, 1'b1);
    chk("post-reset accept valid", 32'(out_valid_id), 32'h1);
    chk("post-reset count", 32'(bubble_count_id), 32'h0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
